// File: rtl/cp0_unit_if.sv
// Pipeline-to-CP0 bundle: CP0 op/addresses from ID, redirect and MFC0 data back.
// master = pipeline controller side, slave = cp0_unit.
interface cp0_unit_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic              inst_valid;
  logic [1:0]        oper;
  logic [4:0]        addr_r;
  logic [DATA_W-1:0] data_r;
  logic [4:0]        addr_w;
  logic [DATA_W-1:0] data_w;
  logic [DATA_W-1:0] ret_addr;
  logic              ir_in;
  logic              jump_en;
  logic [DATA_W-1:0] jump_addr;
  logic              irq_pending;

  modport master (
    output en, inst_valid, oper, addr_r, addr_w, data_w, ret_addr, ir_in,
    input  data_r, jump_en, jump_addr, irq_pending
  );

  modport slave (
    input  en, inst_valid, oper, addr_r, addr_w, data_w, ret_addr, ir_in,
    output data_r, jump_en, jump_addr, irq_pending
  );
endinterface

// File: rtl/cp0_unit.sv
// MIPS CP0: STATUS/CAUSE/EPC/EHBR, interrupt sync + take/ERET redirect.
// Redirect and MFC0 read are combinational; the ID stall (en=0) freezes all but the irq path.
module cp0_unit #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] EHBR_RESET = 'h0000_0100
) (
  input logic         clk,
  input logic         rst,
  cp0_unit_if.slave   bus
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EHBR   = 5'd15;

  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_ERET  = 2'd2;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_HANDLER = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ie;
  logic [DATA_W-1:0] epc;
  logic [DATA_W-1:0] ehbr;
  logic              sync_1;
  logic              sync_2;
  logic              sync_3;
  logic              pending;

  logic              active;
  logic              wr_act;
  logic              eret_act;
  logic              take;
  logic              irq_edge;
  logic [DATA_W-1:0] epc_fwd;
  logic              jump_en_c;
  logic [DATA_W-1:0] jump_addr_c;
  logic [DATA_W-1:0] rd_dat;

  // Gating with rst keeps the redirect quiet while the core is held in reset.
  assign active   = rst & bus.en & bus.inst_valid;
  assign wr_act   = active & (bus.oper == OP_STORE);
  assign eret_act = active & (bus.oper == OP_ERET);
  assign take     = active & pending & ie & ~eret_act;
  assign irq_edge = sync_2 & ~sync_3;
  assign epc_fwd  = (wr_act && bus.addr_w == REG_EPC) ? bus.data_w : epc;

  // Interrupt synchronizer and edge history run regardless of the ID enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= bus.ir_in;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  // A new edge wins over the take so an edge arriving during a take is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (irq_edge) begin
      pending <= 1'b1;
    end else if (take) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    jump_en_c   = 1'b0;
    jump_addr_c = '0;
    case (state)
      S_RUN:     if (take)     state_nxt = S_HANDLER;
      S_HANDLER: if (eret_act) state_nxt = S_RUN;
      default:   state_nxt = S_RUN;
    endcase
    if (eret_act) begin
      jump_en_c   = 1'b1;
      jump_addr_c = epc_fwd;
    end else if (take) begin
      jump_en_c   = 1'b1;
      jump_addr_c = ehbr;
    end
  end

  // Take overrides software writes to STATUS/EPC; EHBR writes always land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie   <= 1'b0;
      epc  <= '0;
      ehbr <= EHBR_RESET;
    end else begin
      if (take) begin
        ie  <= 1'b0;
        epc <= bus.ret_addr;
      end else begin
        if (eret_act) begin
          ie <= 1'b1;
        end else if (wr_act && bus.addr_w == REG_STATUS) begin
          ie <= bus.data_w[0];
        end
        if (wr_act && bus.addr_w == REG_EPC) begin
          epc <= bus.data_w;
        end
      end
      if (wr_act && bus.addr_w == REG_EHBR) begin
        ehbr <= bus.data_w;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    case (bus.addr_r)
      REG_STATUS: rd_dat[0]        = ie;
      REG_CAUSE:  rd_dat[DATA_W-1] = pending;
      REG_EPC:    rd_dat           = epc;
      REG_EHBR:   rd_dat           = ehbr;
      default:    rd_dat           = '0;
    endcase
    if (wr_act && bus.addr_w == bus.addr_r) begin
      rd_dat = bus.data_w;
    end
  end

  assign bus.data_r      = rd_dat;
  assign bus.jump_en     = jump_en_c;
  assign bus.jump_addr   = jump_addr_c;
  assign bus.irq_pending = pending;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus pushes expectations, a negedge monitor checks them.
module tb_cp0_unit;

  logic clk;
  logic rst;

  cp0_unit_if #(.DATA_W(32)) bus ();

  cp0_unit #(
    .DATA_W    (32),
    .EHBR_RESET(32'h0000_0100)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] jq[$];
  string       cname_q[$];
  logic [31:0] cexp_q[$];
  bit          csel_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Everything queued before a negedge is due at that negedge.
  always @(negedge clk) begin
    if (jq.size() > 0) begin
      logic [31:0] ea;
      ea = jq.pop_front();
      cmp("jump_en", {31'b0, bus.jump_en}, 32'd1);
      cmp("jump_addr", bus.jump_addr, ea);
    end else begin
      cmp("jump_en idle", {31'b0, bus.jump_en}, 32'd0);
      cmp("jump_addr idle", bus.jump_addr, 32'd0);
    end
    while (cname_q.size() > 0) begin
      string       n;
      logic [31:0] e;
      bit          s;
      n = cname_q.pop_front();
      e = cexp_q.pop_front();
      s = csel_q.pop_front();
      if (s) cmp(n, {31'b0, bus.irq_pending}, e);
      else   cmp(n, bus.data_r, e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic v, input logic [1:0] op,
                     input logic [4:0] aw, input logic [31:0] dw, input logic [31:0] ra);
    bus.en         = e;
    bus.inst_valid = v;
    bus.oper       = op;
    bus.addr_w     = aw;
    bus.data_w     = dw;
    bus.ret_addr   = ra;
  endtask

  task automatic idle();
    drv(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic exp_rd(input string n, input logic [4:0] a, input logic [31:0] e);
    bus.addr_r = a;
    cname_q.push_back(n);
    cexp_q.push_back(e);
    csel_q.push_back(1'b0);
  endtask

  task automatic exp_pend(input string n, input logic e);
    cname_q.push_back(n);
    cexp_q.push_back({31'b0, e});
    csel_q.push_back(1'b1);
  endtask

  task automatic rd(input string n, input logic [4:0] a, input logic [31:0] e);
    idle();
    exp_rd(n, a, e);
    step();
  endtask

  // Pulse ir_in; pending becomes visible after the third edge.
  task automatic irq_wait();
    idle();
    bus.ir_in = 1'b1;
    step();
    bus.ir_in = 1'b0;
    exp_pend("pend sync1", 1'b0);
    step();
    exp_pend("pend sync2", 1'b0);
    step();
    exp_pend("pend set", 1'b1);
    exp_rd("cause pending", 5'd13, 32'h8000_0000);
    step();
  endtask

  initial begin
    rst = 1'b0;
    bus.addr_r = 5'd0;
    bus.ir_in  = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
    step();

    rd("rst status", 5'd12, 32'h0);
    rd("rst ehbr", 5'd15, 32'h100);
    rd("rst epc", 5'd14, 32'h0);
    exp_pend("rst pend", 1'b0);
    rd("rst cause", 5'd13, 32'h0);

    drv(1'b1, 1'b1, 2'd1, 5'd12, 32'h1, 32'h0);
    exp_rd("bypass status", 5'd12, 32'h1);
    step();
    drv(1'b1, 1'b1, 2'd1, 5'd15, 32'h200, 32'h0);
    step();
    drv(1'b1, 1'b1, 2'd1, 5'd3, 32'hdead_beef, 32'h0);
    step();
    rd("status ie", 5'd12, 32'h1);
    rd("ehbr wr", 5'd15, 32'h200);
    rd("unmapped", 5'd3, 32'h0);

    irq_wait();
    drv(1'b1, 1'b1, 2'd0, 5'd0, 32'h0, 32'h40);
    jq.push_back(32'h200);
    step();
    exp_pend("pend cleared", 1'b0);
    rd("epc take", 5'd14, 32'h40);
    rd("ie cleared", 5'd12, 32'h0);

    drv(1'b1, 1'b1, 2'd2, 5'd0, 32'h0, 32'h0);
    jq.push_back(32'h40);
    step();
    rd("ie eret", 5'd12, 32'h1);

    // Pending with IE=0 waits until software re-enables.
    drv(1'b1, 1'b1, 2'd1, 5'd12, 32'h0, 32'h0);
    step();
    irq_wait();
    drv(1'b1, 1'b1, 2'd0, 5'd0, 32'h0, 32'h50);
    step();
    drv(1'b1, 1'b1, 2'd1, 5'd12, 32'h1, 32'h54);
    exp_pend("pend held ie0", 1'b1);
    step();
    drv(1'b1, 1'b1, 2'd0, 5'd0, 32'h0, 32'h58);
    jq.push_back(32'h200);
    step();
    rd("epc late take", 5'd14, 32'h58);
    drv(1'b1, 1'b1, 2'd2, 5'd0, 32'h0, 32'h0);
    jq.push_back(32'h58);
    step();

    // Stall: nothing but the irq path may change.
    irq_wait();
    drv(1'b0, 1'b1, 2'd1, 5'd15, 32'h999, 32'h64);
    step();
    drv(1'b0, 1'b1, 2'd2, 5'd0, 32'h0, 32'h64);
    exp_pend("pend stall", 1'b1);
    step();
    drv(1'b1, 1'b1, 2'd0, 5'd0, 32'h0, 32'h68);
    jq.push_back(32'h200);
    step();
    rd("epc after stall", 5'd14, 32'h68);
    rd("ehbr stall wr", 5'd15, 32'h200);
    drv(1'b1, 1'b1, 2'd2, 5'd0, 32'h0, 32'h0);
    jq.push_back(32'h68);
    step();

    irq_wait();
    drv(1'b1, 1'b1, 2'd2, 5'd0, 32'h0, 32'h6c);
    jq.push_back(32'h68);
    step();
    exp_pend("pend after eret", 1'b1);
    idle();
    step();
    drv(1'b1, 1'b1, 2'd0, 5'd0, 32'h0, 32'h70);
    jq.push_back(32'h200);
    step();

    drv(1'b1, 1'b1, 2'd1, 5'd14, 32'h80, 32'h0);
    exp_rd("bypass epc", 5'd14, 32'h80);
    step();
    rd("epc mtc0", 5'd14, 32'h80);
    drv(1'b1, 1'b1, 2'd2, 5'd0, 32'h0, 32'h0);
    jq.push_back(32'h80);
    step();
    rd("ie after eret2", 5'd12, 32'h1);

    // Take overrides a same-cycle MTC0 to EPC.
    irq_wait();
    drv(1'b1, 1'b1, 2'd1, 5'd14, 32'h1234, 32'h90);
    jq.push_back(32'h200);
    step();
    rd("epc take wins", 5'd14, 32'h90);
    rd("ie handler", 5'd12, 32'h0);

    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    rd("rst2 status", 5'd12, 32'h0);
    rd("rst2 ehbr", 5'd15, 32'h100);
    exp_pend("rst2 pend", 1'b0);
    rd("rst2 epc", 5'd14, 32'h0);

    drv(1'b1, 1'b1, 2'd2, 5'd0, 32'h0, 32'h0);
    jq.push_back(32'h0);
    step();
    rd("ie eret run", 5'd12, 32'h1);

    idle();
    @(negedge clk);
    #1;
    cmp("jump queue drained", jq.size(), 32'd0);
    cmp("check queue drained", cname_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
